// File: rtl/clock_pkg.sv
// Shared constants and types for the BCD time-of-day counter.
package clock_pkg;

    // Width of one packed-BCD digit.
    localparam int unsigned BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    // Largest value a low digit may hold before it wraps into its high digit.
    localparam bcd_digit_t BCD_NINE = bcd_digit_t'(9);

    // Two-digit rollover points for each field of the 24 h clock.
    localparam int unsigned SEC_MAX_HI = 5;
    localparam int unsigned SEC_MAX_LO = 9;
    localparam int unsigned MIN_MAX_HI = 5;
    localparam int unsigned MIN_MAX_LO = 9;
    localparam int unsigned HR_MAX_HI  = 2;
    localparam int unsigned HR_MAX_LO  = 3;

endpackage : clock_pkg

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that rolls over to 00 after MAX_HI:MAX_LO.
// The wrap flag is combinational so counters can be chained on one edge.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int unsigned MAX_HI = 5,
    parameter int unsigned MAX_LO = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] lo,
    output logic [BCD_W-1:0] hi,
    output logic             wrap
);

    localparam bcd_digit_t LIM_HI = bcd_digit_t'(MAX_HI);
    localparam bcd_digit_t LIM_LO = bcd_digit_t'(MAX_LO);

    bcd_digit_t lo_q, lo_d;
    bcd_digit_t hi_q, hi_d;
    logic       at_max;

    assign at_max = (hi_q == LIM_HI) && (lo_q == LIM_LO);
    assign wrap   = inc && at_max;

    // Next-state: clear wins over increment; the low digit carries into the high digit at 9.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
        lo_d = lo_q;
        hi_d = hi_q;
        if (clr) begin
            lo_d = '0;
            hi_d = '0;
        end else if (inc) begin
            if (at_max) begin
                lo_d = '0;
                hi_d = '0;
            end else if (lo_q == BCD_NINE) begin
                lo_d = '0;
                hi_d = hi_q + bcd_digit_t'(1);
            end else begin
                lo_d = lo_q + bcd_digit_t'(1);
            end
        end
    end

    // Digit registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (rst) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign lo = lo_q;
    assign hi = hi_q;

endmodule : bcd_mod_counter

// File: rtl/bcd_time_counter.sv
// Time-of-day core: divides clk to a 1 Hz tick and keeps HH:MM:SS in BCD.
// In set mode seconds are held at 00 and minutes/hours step on pulses.
module bcd_time_counter
    import clock_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             set_mode,
    input  logic             inc_min,
    input  logic             inc_hr,
    output logic             tick_1hz,
    output logic             day_carry,
    output logic [BCD_W-1:0] sec_lo,
    output logic [BCD_W-1:0] sec_hi,
    output logic [BCD_W-1:0] min_lo,
    output logic [BCD_W-1:0] min_hi,
    output logic [BCD_W-1:0] hr_lo,
    output logic [BCD_W-1:0] hr_hi
);

    localparam int unsigned      CNT_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             day_q, day_d;

    logic advance;
    logic cnt_wrap;
    logic sec_inc, min_inc, hr_inc;
    logic sec_wrap, min_wrap, hr_wrap;

    // The prescaler only runs in normal timekeeping; set mode parks it at 0.
    assign advance  = run && !set_mode;
    assign cnt_wrap = advance && (cnt_q == CNT_LAST);

    // Prescaler next-state and the strobes derived from it.
    always_comb begin
        cnt_d = cnt_q;
        if (set_mode) begin
            cnt_d = '0;
        end else if (advance) begin
            cnt_d = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
        end
        tick_d = cnt_wrap;
        // Adjusting hours through 23 -> 00 is not a real day rollover.
        day_d  = hr_wrap && !set_mode;
    end

    // Prescaler and strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            day_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            day_q  <= day_d;
        end
    end

    // Field chaining: ticks ripple sec -> min -> hr normally; pulses drive min/hr
    // directly in set mode, with no carry between them.
    assign sec_inc = tick_q && !set_mode;
    assign min_inc = set_mode ? inc_min : sec_wrap;
    assign hr_inc  = set_mode ? inc_hr  : min_wrap;

    bcd_mod_counter #(
        .MAX_HI (SEC_MAX_HI),
        .MAX_LO (SEC_MAX_LO)
    ) u_sec (
        .clk  (clk),
        .rst  (rst),
        .clr  (set_mode),
        .inc  (sec_inc),
        .lo   (sec_lo),
        .hi   (sec_hi),
        .wrap (sec_wrap)
    );

    bcd_mod_counter #(
        .MAX_HI (MIN_MAX_HI),
        .MAX_LO (MIN_MAX_LO)
    ) u_min (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .inc  (min_inc),
        .lo   (min_lo),
        .hi   (min_hi),
        .wrap (min_wrap)
    );

    bcd_mod_counter #(
        .MAX_HI (HR_MAX_HI),
        .MAX_LO (HR_MAX_LO)
    ) u_hr (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .inc  (hr_inc),
        .lo   (hr_lo),
        .hi   (hr_hi),
        .wrap (hr_wrap)
    );

    assign tick_1hz  = tick_q;
    assign day_carry = day_q;

endmodule : bcd_time_counter
